ftdi_fifo_arbiter: RTL and testbench

Sequences the shared FTDI FT232H asynchronous 245-FIFO port (ADBUS data, RXF#/TXE# status, RD#/WR# strobes) and arbitrates its direction between the host-to-laser read path and the laser-to-host write path. It sits between the FPGA pin mapping and the laser TX/RX datapaths, owns the ADBUS tri-state enable, and guarantees that the FPGA and the FTDI never drive the bus at the same time. Both paths get a simple valid/ready byte interface, so neither datapath handles FTDI pulse timing.

---
 rtl/ftdi_pkg.sv | 33 +++
 rtl/ftdi_fifo_arbiter_if.sv | 35 +++
 rtl/ftdi_fifo_arbiter_bit_sync.sv | 27 ++
 rtl/ftdi_fifo_arbiter.sv | 130 +++++++++++++
 tb/tb_ftdi_fifo_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ftdi_pkg.sv
// ftdi_pkg
//   Shared types and default timing for the FT232H 245-FIFO arbiter.
//   ftdi_state_t : transaction sequencer states
//   ftdi_dir_t   : direction of the last grant (round-robin tie-break)
//   *_DEF        : default pulse/recovery/synchronizer depths in clock cycles
package ftdi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_RECOVER
    } ftdi_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ftdi_dir_t;

    localparam int RD_PULSE_DEF    = 3;
    localparam int WR_PULSE_DEF    = 3;
    localparam int RECOVER_DEF     = 3;
    localparam int SYNC_STAGES_DEF = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ftdi_fifo_arbiter_if.sv
// ftdi_fifo_arbiter_if
//   Bundles the FTDI pin-side signals and the two byte-stream handshakes.
//   slave  : arbiter view (drives strobes, ADBUS, rd_*, wr_ready, busy)
//   master : environment view (drives FTDI status, ADBUS pins, requesters)
interface ftdi_fifo_arbiter_if;

    logic       en;
    logic       rxf_n;
    logic       txe_n;
    logic [7:0] adbus_in;
    logic [7:0] adbus_out;
    logic       adbus_oe;
    logic       ftdi_rd_n;
    logic       ftdi_wr_n;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;

    modport slave (
        input  en, rxf_n, txe_n, adbus_in, rd_ready, wr_valid, wr_data,
        output adbus_out, adbus_oe, ftdi_rd_n, ftdi_wr_n, rd_data, rd_valid,
               wr_ready, busy
    );

    modport master (
        output en, rxf_n, txe_n, adbus_in, rd_ready, wr_valid, wr_data,
        input  adbus_out, adbus_oe, ftdi_rd_n, ftdi_wr_n, rd_data, rd_valid,
               wr_ready, busy
    );

endinterface

// File: rtl/ftdi_fifo_arbiter_bit_sync.sv
// bit_sync
//   STAGES-deep flop chain bringing an asynchronous level into the clock
//   domain. The chain loads rst_val on synchronous reset so the synchronized
//   output starts in a known (inactive) state.
//   clock, reset_n : clock, synchronous active-low reset
//   rst_val        : value every stage takes during reset
//   d / q          : asynchronous input / synchronized output
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock) begin
        if (!reset_n) chain <= {STAGES{rst_val}};
        else          chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ftdi_fifo_arbiter.sv
// ftdi_fifo_arbiter
//   Sequences the FT232H async 245-FIFO port and arbitrates its direction
//   between the host->laser read path and the laser->host write path.
//   Owns the ADBUS tri-state enable; ADBUS is only driven in the write states.
//   clock, reset_n : system clock, synchronous active-low reset
//   bus (slave)    : FTDI pins (rxf_n, txe_n, adbus_*, ftdi_rd_n, ftdi_wr_n),
//                    read stream (rd_ready, rd_data, rd_valid),
//                    write stream (wr_valid, wr_data, wr_ready), en, busy
//   RECOVER must be >= SYNC_STAGES+1 and >= 2 so stale status is not re-used.
module ftdi_fifo_arbiter
    import ftdi_pkg::*;
#(
    parameter int RD_PULSE    = RD_PULSE_DEF,
    parameter int WR_PULSE    = WR_PULSE_DEF,
    parameter int RECOVER     = RECOVER_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic              clock,
    input logic              reset_n,
    ftdi_fifo_arbiter_if.slave bus
);

    localparam int CNT_MAX = max3(RD_PULSE, WR_PULSE, RECOVER);
    localparam int CW      = $clog2(CNT_MAX + 1);

    ftdi_state_t     state, state_next;
    ftdi_dir_t       last_dir;
    logic [CW-1:0]   cnt, cnt_next;
    logic            rxf_s, txe_s;
    logic            rd_elig, wr_elig;
    logic            grant_rd, grant_wr;
    logic            rd_sample;
    logic [7:0]      adbus_out_q, rd_data_q;
    logic            rd_valid_q;

    // Status synchronizers reset to 1 so nothing looks available out of reset.
    bit_sync #(.STAGES(SYNC_STAGES)) u_rxf_sync (
        .clock(clock), .reset_n(reset_n), .rst_val(1'b1), .d(bus.rxf_n), .q(rxf_s)
    );
    bit_sync #(.STAGES(SYNC_STAGES)) u_txe_sync (
        .clock(clock), .reset_n(reset_n), .rst_val(1'b1), .d(bus.txe_n), .q(txe_s)
    );

    assign rd_elig = bus.en && !rxf_s && bus.rd_ready;
    assign wr_elig = bus.en && !txe_s && bus.wr_valid;

    // Round-robin only matters on contention: go opposite to last grant.
    assign grant_rd = (state == ST_IDLE) && rd_elig && (!wr_elig || last_dir == WRITE);
    assign grant_wr = (state == ST_IDLE) && wr_elig && (!rd_elig || last_dir == READ);

    assign rd_sample = (state == ST_RD_STROBE) && (cnt == '0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (grant_rd) begin
                    state_next = ST_RD_STROBE;
                    cnt_next   = CW'(RD_PULSE - 1);
                end else if (grant_wr) begin
                    state_next = ST_WR_SETUP;
                end
            end
            ST_RD_STROBE: begin
                if (cnt == '0) begin
                    state_next = ST_RECOVER;
                    cnt_next   = CW'(RECOVER - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_WR_SETUP: begin
                state_next = ST_WR_STROBE;
                cnt_next   = CW'(WR_PULSE - 1);
            end
            ST_WR_STROBE: begin
                if (cnt == '0) state_next = ST_WR_HOLD;
                else           cnt_next   = cnt - CW'(1);
            end
            ST_WR_HOLD: begin
                // Hold already spent one idle-strobe cycle, so recover one less.
                state_next = ST_RECOVER;
                cnt_next   = CW'(RECOVER - 2);
            end
            ST_RECOVER: begin
                if (cnt == '0) state_next = ST_IDLE;
                else           cnt_next   = cnt - CW'(1);
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_dir    <= WRITE;
            adbus_out_q <= 8'h00;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            rd_valid_q <= rd_sample;
            if (rd_sample) rd_data_q <= bus.adbus_in;
            if (grant_rd)  last_dir  <= READ;
            if (grant_wr) begin
                last_dir    <= WRITE;
                adbus_out_q <= bus.wr_data;
            end
        end
    end

    // Strobes and OE decode straight from state, so a reset clears them on
    // the same edge that returns the FSM to IDLE.
    assign bus.adbus_oe  = (state == ST_WR_SETUP) || (state == ST_WR_STROBE) ||
                           (state == ST_WR_HOLD);
    assign bus.ftdi_rd_n = (state != ST_RD_STROBE);
    assign bus.ftdi_wr_n = (state != ST_WR_STROBE);
    assign bus.adbus_out = adbus_out_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_ready  = grant_wr;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// tb_ftdi_fifo_arbiter
//   Directed bench for ftdi_fifo_arbiter: reset, single read/write timing,
//   contention alternation, back-pressure, status drop mid-write, abort.
module tb_ftdi_fifo_arbiter;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    logic prev_oe = 1'b0;

    always #5 clock = ~clock;

    ftdi_fifo_arbiter_if bus();

    ftdi_fifo_arbiter dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Bus-safety monitor: never read while driving, and a gap after writes.
    always @(negedge clock) begin
        checks++;
        if (!bus.ftdi_rd_n && bus.adbus_oe) begin
            errors++;
            $display("FAIL bus_conflict: rd_n=%b oe=%b, required oe=0 while rd_n=0",
                     bus.ftdi_rd_n, bus.adbus_oe);
        end
        checks++;
        if (!bus.ftdi_rd_n && prev_oe) begin
            errors++;
            $display("FAIL wr_rd_gap: rd_n low right after oe=1, required an idle cycle");
        end
        prev_oe = bus.adbus_oe;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        bus.en       = 1'b1;
        bus.rxf_n    = 1'b1;
        bus.txe_n    = 1'b1;
        bus.adbus_in = 8'h00;
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset;
        logic [19:0] obs;
        int n;
        idle_inputs();
        bus.rxf_n    = 1'b0;
        bus.rd_ready = 1'b1;
        reset_n      = 1'b0;
        repeat (3) tick();
        // {oe, out, rd_n, wr_n, rd_valid, rd_data, wr_ready, busy}
        obs = {bus.adbus_oe, bus.adbus_out, bus.ftdi_rd_n, bus.ftdi_wr_n,
               bus.rd_valid, bus.rd_data[5:0], bus.wr_ready, bus.busy};
        checks++;
        if (obs !== {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", obs,
                     {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0});
        end
        checks++;
        if (bus.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %h required 00", bus.rd_data);
        end
        reset_n = 1'b1;
        n = 0;
        while (bus.ftdi_rd_n && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL reset_first_strobe: rd_n low after %0d cycles required 3", n);
        end
        bus.rxf_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_single_read;
        int lo = 0, vcnt = 0, first = -1, vidx = -1, idle_idx = -1;
        logic [7:0] vdata = 8'h00;
        logic oe_seen = 1'b0;
        do_reset();
        bus.adbus_in = 8'hA5;
        bus.rd_ready = 1'b1;
        bus.rxf_n    = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (!bus.ftdi_rd_n) begin
                lo++;
                if (first < 0) first = i;
                bus.rxf_n = 1'b1;
            end
            if (bus.rd_valid) begin
                vcnt++;
                vidx  = i;
                vdata = bus.rd_data;
            end
            if (bus.adbus_oe) oe_seen = 1'b1;
            if (first >= 0 && !bus.busy && idle_idx < 0) idle_idx = i;
        end
        checks++;
        if (lo !== 3) begin
            errors++; $display("FAIL read_strobe_len: got %0d required 3", lo);
        end
        checks++;
        if (vcnt !== 1) begin
            errors++; $display("FAIL read_valid_count: got %0d required 1", vcnt);
        end
        checks++;
        if (vdata !== 8'hA5) begin
            errors++; $display("FAIL read_data: got %h required a5", vdata);
        end
        checks++;
        if (oe_seen !== 1'b0) begin
            errors++; $display("FAIL read_oe: got oe=1 during read, required 0");
        end
        checks++;
        if (vidx !== first + 3) begin
            errors++; $display("FAIL read_valid_time: got %0d required %0d", vidx, first + 3);
        end
        checks++;
        if (idle_idx !== first + 6) begin
            errors++; $display("FAIL read_idle_time: got %0d required %0d", idle_idx, first + 6);
        end
    endtask

    task automatic test_single_write;
        int rcnt = 0, ridx = -1, ocnt = 0, ofirst = -1, wcnt = 0;
        int outside = 0, bad = 0, idle_idx = -1;
        logic drop = 1'b0;
        do_reset();
        bus.wr_data  = 8'h3C;
        bus.wr_valid = 1'b1;
        bus.txe_n    = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (drop) begin
                bus.wr_valid = 1'b0;
                bus.txe_n    = 1'b1;
                drop         = 1'b0;
            end
            if (bus.wr_ready) begin
                rcnt++;
                ridx = i;
                drop = 1'b1;
            end
            if (bus.adbus_oe) begin
                ocnt++;
                if (ofirst < 0) ofirst = i;
                if (bus.adbus_out !== 8'h3C) bad++;
            end
            if (!bus.ftdi_wr_n) begin
                wcnt++;
                if (!bus.adbus_oe) outside++;
            end
            if (ridx >= 0 && i > ridx && !bus.busy && idle_idx < 0) idle_idx = i;
        end
        checks++;
        if (rcnt !== 1) begin
            errors++; $display("FAIL write_ready_count: got %0d required 1", rcnt);
        end
        // SETUP + 3 STROBE + HOLD all drive the bus.
        checks++;
        if (ocnt !== 5) begin
            errors++; $display("FAIL write_oe_len: got %0d required 5", ocnt);
        end
        checks++;
        if (wcnt !== 3 || outside !== 0) begin
            errors++; $display("FAIL write_strobe: got len %0d outside_oe %0d required 3 and 0", wcnt, outside);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL write_data: got %0d bad cycles required 0 (data 3c)", bad);
        end
        checks++;
        if (ofirst !== ridx + 1) begin
            errors++; $display("FAIL write_oe_time: got %0d required %0d", ofirst, ridx + 1);
        end
        checks++;
        if (idle_idx !== ridx + 8) begin
            errors++; $display("FAIL write_idle_time: got %0d required %0d", idle_idx, ridx + 8);
        end
    endtask

    task automatic test_contention;
        logic [7:0]  g [4];
        logic [31:0] seq, want;
        int gn = 0;
        logic p_rd = 1'b1, p_oe = 1'b0;
        want = "RWRW";
        for (int k = 0; k < 4; k++) g[k] = 8'h00;
        do_reset();
        bus.rxf_n    = 1'b0;
        bus.txe_n    = 1'b0;
        bus.rd_ready = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h5A;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (p_rd && !bus.ftdi_rd_n && gn < 4) begin g[gn] = "R"; gn++; end
            if (!p_oe && bus.adbus_oe && gn < 4)  begin g[gn] = "W"; gn++; end
            p_rd = bus.ftdi_rd_n;
            p_oe = bus.adbus_oe;
        end
        seq = {g[0], g[1], g[2], g[3]};
        checks++;
        if (seq !== want) begin
            errors++; $display("FAIL contention_order: got %s required %s", seq, want);
        end
    endtask

    task automatic test_back_pressure;
        int lo = 0, bz = 0;
        do_reset();
        bus.rxf_n    = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (8) begin
            tick();
            if (!bus.ftdi_rd_n) lo++;
            if (bus.busy) bz++;
        end
        checks++;
        if (lo !== 0 || bz !== 0) begin
            errors++; $display("FAIL bp_not_ready: got rd_n_low %0d busy %0d required 0 0", lo, bz);
        end
        bus.en       = 1'b0;
        bus.rd_ready = 1'b1;
        repeat (6) begin
            tick();
            if (!bus.ftdi_rd_n) lo++;
        end
        checks++;
        if (lo !== 0) begin
            errors++; $display("FAIL bp_en_low: got rd_n_low %0d required 0", lo);
        end
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.ftdi_rd_n !== 1'b0) begin
            errors++; $display("FAIL bp_release: got rd_n=%b required 0", bus.ftdi_rd_n);
        end
        bus.rxf_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_txe_mid_write;
        int rises = 0, wcnt = 0;
        logic p_oe = 1'b0, dropped = 1'b0;
        do_reset();
        bus.wr_data  = 8'hC3;
        bus.wr_valid = 1'b1;
        bus.txe_n    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!bus.ftdi_wr_n) begin
                wcnt++;
                if (!dropped) begin
                    bus.txe_n = 1'b1;
                    dropped   = 1'b1;
                end
            end
            if (!p_oe && bus.adbus_oe) rises++;
            p_oe = bus.adbus_oe;
        end
        checks++;
        if (rises !== 1) begin
            errors++; $display("FAIL txe_drop_writes: got %0d writes required 1", rises);
        end
        checks++;
        if (wcnt !== 3) begin
            errors++; $display("FAIL txe_drop_strobe: got %0d required 3", wcnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL txe_drop_idle: got busy=%b required 0", bus.busy);
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_abort;
        int n = 0, vc = 0, rc = 0;
        do_reset();
        bus.wr_data  = 8'hF0;
        bus.wr_valid = 1'b1;
        bus.txe_n    = 1'b0;
        while (bus.ftdi_wr_n && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++; $display("FAIL abort_timeout: wr_n never went low within 20 cycles");
        end
        tick();
        checks++;
        if (bus.ftdi_wr_n !== 1'b0) begin
            errors++; $display("FAIL abort_setup: got wr_n=%b required 0 in strobe cycle 2", bus.ftdi_wr_n);
        end
        reset_n      = 1'b0;
        bus.txe_n    = 1'b1;
        bus.wr_valid = 1'b0;
        tick();
        checks++;
        if ({bus.ftdi_wr_n, bus.adbus_oe, bus.busy, bus.rd_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_outputs: got wr_n/oe/busy/rd_valid=%b required 1000",
                     {bus.ftdi_wr_n, bus.adbus_oe, bus.busy, bus.rd_valid});
        end
        checks++;
        if (bus.adbus_out !== 8'h00) begin
            errors++; $display("FAIL abort_adbus_out: got %h required 00", bus.adbus_out);
        end
        tick();
        reset_n = 1'b1;
        repeat (12) begin
            tick();
            if (bus.rd_valid) vc++;
            if (bus.wr_ready) rc++;
        end
        checks++;
        if (vc !== 0 || rc !== 0) begin
            errors++; $display("FAIL abort_quiet: got rd_valid %0d wr_ready %0d required 0 0", vc, rc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_back_pressure();
        test_txe_mid_write();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
